// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/write-back,
// stretches memory states while the memory is not ready, and parks in a
// sticky TRAP state on an illegal opcode or a memory watchdog timeout.
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal,
  output logic               bus_err
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // A zero TIMEOUT still needs a one-bit counter to keep the logic legal.
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXEC,
    ALUWB,
    BRANCH,
    JUMP,
    TRAP
  } state_t;

  state_t          state;
  logic [5:0]      op_q;
  logic [WD_W-1:0] wd;
  logic            in_wait;
  logic            timeout_hit;

  // Watchdog fires on the edge that would complete the TIMEOUT-th not-ready cycle.
  always_comb begin
    in_wait     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    timeout_hit = (TIMEOUT != 0) && in_wait && !mem_ready && (wd == WD_LAST);
  end

  // State sequencing, opcode latch, watchdog count and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      wd      <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (in_wait && !mem_ready) begin
        wd <= wd + 1'b1;
      end else begin
        wd <= '0;
      end

      if (timeout_hit) begin
        state   <= TRAP;
        bus_err <= 1'b1;
      end else begin
        case (state)
          IDLE:     state <= FETCH;
          FETCH:    if (mem_ready) state <= DECODE;
          DECODE: begin
            op_q <= opcode;
            case (opcode)
              OP_LW, OP_SW:                       state <= MEMADR;
              OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: state <= EXEC;
              OP_BEQ:                             state <= BRANCH;
              OP_J:                               state <= JUMP;
              default: begin
                state   <= TRAP;
                illegal <= 1'b1;
              end
            endcase
          end
          MEMADR:   state <= (op_q == OP_LW) ? MEMREAD : MEMWRITE;
          MEMREAD:  if (mem_ready) state <= MEMWB;
          MEMWB:    state <= FETCH;
          MEMWRITE: if (mem_ready) state <= FETCH;
          EXEC:     state <= ALUWB;
          ALUWB:    state <= FETCH;
          BRANCH:   state <= FETCH;
          JUMP:     state <= FETCH;
          TRAP:     state <= TRAP;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  // Moore decode of datapath controls; only the wait-state handshakes look at mem_ready.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = '0;
    instr_done  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALUOP_W'(3'b010);
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALUOP_W'(3'b010);
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALUOP_W'(3'b010);
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (op_q == OP_RTYPE) ? 2'b00 : 2'b10;
        case (op_q)
          OP_RTYPE: ALUOp = ALUOP_W'(3'b100);
          OP_ANDI:  ALUOp = ALUOP_W'(3'b000);
          OP_ORI:   ALUOp = ALUOP_W'(3'b001);
          default:  ALUOp = ALUOP_W'(3'b010);
        endcase
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = (op_q == OP_RTYPE);
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(3'b011);
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for the multicycle control FSM.
// Expected controls come from per-instruction phase templates; each cycle
// the bench drives mem_ready/opcode and compares the whole control word.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Bit positions inside the packed control word.
  localparam int B_PCW = 19, B_PCWC = 18, B_IORD = 17, B_MRD = 16, B_MWR = 15;
  localparam int B_IRW = 14, B_M2R = 13, B_RDST = 12, B_RW = 11, B_ASA = 10;
  localparam int B_ASB = 8, B_PSRC = 6, B_AOP = 3, B_DONE = 2, B_ILL = 1, B_BERR = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        instr_done, illegal, bus_err;
  logic [19:0] got;

  int checks = 0;
  int errors = 0;
  int cyc_no, done_at, done_count;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         cycles;
    string      name;
  } vec_t;

  vec_t       tbl[12];
  logic [5:0] legal_ops[8];

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                instr_done, illegal, bus_err};

  function automatic logic [19:0] fetch_exp(input logic r);
    logic [19:0] e = '0;
    e[B_MRD] = 1'b1; e[B_ASB +: 2] = 2'b01; e[B_AOP +: 3] = 3'b010;
    e[B_PCW] = r;    e[B_IRW] = r;
    return e;
  endfunction

  function automatic logic [19:0] decode_exp();
    logic [19:0] e = '0;
    e[B_ASB +: 2] = 2'b11; e[B_AOP +: 3] = 3'b010;
    return e;
  endfunction

  function automatic logic [19:0] adr_exp();
    logic [19:0] e = '0;
    e[B_ASA] = 1'b1; e[B_ASB +: 2] = 2'b10; e[B_AOP +: 3] = 3'b010;
    return e;
  endfunction

  function automatic logic [19:0] memrd_exp();
    logic [19:0] e = '0;
    e[B_MRD] = 1'b1; e[B_IORD] = 1'b1;
    return e;
  endfunction

  function automatic logic [19:0] memwb_exp();
    logic [19:0] e = '0;
    e[B_M2R] = 1'b1; e[B_RW] = 1'b1; e[B_DONE] = 1'b1;
    return e;
  endfunction

  function automatic logic [19:0] memwr_exp(input logic r);
    logic [19:0] e = '0;
    e[B_MWR] = 1'b1; e[B_IORD] = 1'b1; e[B_DONE] = r;
    return e;
  endfunction

  function automatic logic [19:0] exec_exp(input logic [5:0] op);
    logic [19:0] e = '0;
    e[B_ASA] = 1'b1;
    e[B_ASB +: 2] = (op == OP_R) ? 2'b00 : 2'b10;
    e[B_AOP +: 3] = (op == OP_R) ? 3'b100 : (op == OP_ANDI) ? 3'b000 :
                    (op == OP_ORI) ? 3'b001 : 3'b010;
    return e;
  endfunction

  function automatic logic [19:0] aluwb_exp(input logic [5:0] op);
    logic [19:0] e = '0;
    e[B_RW] = 1'b1; e[B_RDST] = (op == OP_R); e[B_DONE] = 1'b1;
    return e;
  endfunction

  function automatic logic [19:0] branch_exp();
    logic [19:0] e = '0;
    e[B_ASA] = 1'b1; e[B_AOP +: 3] = 3'b011; e[B_PCWC] = 1'b1;
    e[B_PSRC +: 2] = 2'b01; e[B_DONE] = 1'b1;
    return e;
  endfunction

  function automatic logic [19:0] jump_exp();
    logic [19:0] e = '0;
    e[B_PCW] = 1'b1; e[B_PSRC +: 2] = 2'b10; e[B_DONE] = 1'b1;
    return e;
  endfunction

  function automatic logic [19:0] trap_exp(input logic ill, input logic berr);
    logic [19:0] e = '0;
    e[B_ILL] = ill; e[B_BERR] = berr;
    return e;
  endfunction

  // Cycles per instruction with no waits, plus one per wait cycle.
  function automatic int cpi(input logic [5:0] op, input int fw, input int mw);
    case (op)
      OP_LW:         return 5 + fw + mw;
      OP_SW:         return 4 + fw + mw;
      OP_BEQ, OP_J:  return 3 + fw;
      default:       return 4 + fw;
    endcase
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%05h required=%05h", name, actual, expected);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [5:0] op,
                               input logic [19:0] expected, input string name);
    @(negedge clk);
    mem_ready = ready;
    opcode    = op;
    #1;
    cyc_no++;
    if (instr_done) begin
      done_count++;
      if (done_at == 0) done_at = cyc_no;
    end
    checkOutput(name, got, expected);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", got, '0);
    rst_n = 1'b1;
    #1;
    checkOutput("idle", got, '0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int exp_cycles, input string name);
    cyc_no = 0; done_at = 0; done_count = 0;
    for (int i = 0; i < fw; i++)
      applyStimulus(1'b0, rnd_op(), fetch_exp(1'b0), {name, "/fetch_wait"});
    applyStimulus(1'b1, rnd_op(), fetch_exp(1'b1), {name, "/fetch"});
    applyStimulus(1'($urandom_range(0, 1)), op, decode_exp(), {name, "/decode"});
    case (op)
      OP_LW: begin
        applyStimulus(1'($urandom_range(0, 1)), rnd_op(), adr_exp(), {name, "/memadr"});
        for (int i = 0; i < mw; i++)
          applyStimulus(1'b0, rnd_op(), memrd_exp(), {name, "/memread_wait"});
        applyStimulus(1'b1, rnd_op(), memrd_exp(), {name, "/memread"});
        applyStimulus(1'($urandom_range(0, 1)), rnd_op(), memwb_exp(), {name, "/memwb"});
      end
      OP_SW: begin
        applyStimulus(1'($urandom_range(0, 1)), rnd_op(), adr_exp(), {name, "/memadr"});
        for (int i = 0; i < mw; i++)
          applyStimulus(1'b0, rnd_op(), memwr_exp(1'b0), {name, "/memwrite_wait"});
        applyStimulus(1'b1, rnd_op(), memwr_exp(1'b1), {name, "/memwrite"});
      end
      OP_BEQ: applyStimulus(1'($urandom_range(0, 1)), rnd_op(), branch_exp(), {name, "/branch"});
      OP_J:   applyStimulus(1'($urandom_range(0, 1)), rnd_op(), jump_exp(), {name, "/jump"});
      default: begin
        applyStimulus(1'($urandom_range(0, 1)), rnd_op(), exec_exp(op), {name, "/exec"});
        applyStimulus(1'($urandom_range(0, 1)), rnd_op(), aluwb_exp(op), {name, "/aluwb"});
      end
    endcase
    check_int({name, "/done_cycle"}, done_at, exp_cycles);
    check_int({name, "/done_count"}, done_count, 1);
  endtask

  initial begin
    tbl[0]  = '{OP_LW,   0,  0,  5, "lw"};
    tbl[1]  = '{OP_LW,   3,  0,  8, "lw_fetch3"};
    tbl[2]  = '{OP_BEQ,  0,  0,  3, "beq"};
    tbl[3]  = '{OP_J,    0,  0,  3, "j"};
    tbl[4]  = '{OP_ORI,  0,  0,  4, "ori"};
    tbl[5]  = '{OP_R,    0,  0,  4, "rtype"};
    tbl[6]  = '{OP_ADDI, 0,  0,  4, "addi"};
    tbl[7]  = '{OP_ANDI, 0,  0,  4, "andi"};
    tbl[8]  = '{OP_SW,   0,  0,  4, "sw"};
    tbl[9]  = '{OP_SW,   1,  3,  8, "sw_waits"};
    tbl[10] = '{OP_LW,   0,  2,  7, "lw_mem2"};
    tbl[11] = '{OP_LW,   15, 15, 35, "lw_wait15"};
    legal_ops = '{OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};

    #2;
    apply_reset();

    for (int i = 0; i < 12; i++)
      run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, tbl[i].cycles, tbl[i].name);

    // Illegal opcode: sticky trap until reset.
    applyStimulus(1'b1, rnd_op(), fetch_exp(1'b1), "ill/fetch");
    applyStimulus(1'b1, 6'b111111, decode_exp(), "ill/decode");
    for (int i = 0; i < 50; i++)
      applyStimulus(1'($urandom_range(0, 1)), rnd_op(), trap_exp(1'b1, 1'b0), "ill/trap");
    apply_reset();

    // Watchdog in MEMREAD: 16 not-ready cycles trap with bus_err.
    applyStimulus(1'b1, rnd_op(), fetch_exp(1'b1), "wd/fetch");
    applyStimulus(1'b1, OP_LW, decode_exp(), "wd/decode");
    applyStimulus(1'b0, rnd_op(), adr_exp(), "wd/memadr");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, rnd_op(), memrd_exp(), "wd/memread_wait");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'($urandom_range(0, 1)), rnd_op(), trap_exp(1'b0, 1'b1), "wd/trap");
    apply_reset();

    // Watchdog in FETCH.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, rnd_op(), fetch_exp(1'b0), "wdf/fetch_wait");
    applyStimulus(1'b1, rnd_op(), trap_exp(1'b0, 1'b1), "wdf/trap");
    apply_reset();

    // Asynchronous reset in the middle of a store wait.
    applyStimulus(1'b1, rnd_op(), fetch_exp(1'b1), "ar/fetch");
    applyStimulus(1'b1, OP_SW, decode_exp(), "ar/decode");
    applyStimulus(1'b0, rnd_op(), adr_exp(), "ar/memadr");
    applyStimulus(1'b0, rnd_op(), memwr_exp(1'b0), "ar/memwrite_wait");
    applyStimulus(1'b0, rnd_op(), memwr_exp(1'b0), "ar/memwrite_wait");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar/async_reset", got, '0);
    apply_reset();

    // Random legal instruction stream with random wait states.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = legal_ops[$urandom_range(0, 7)];
      fw = $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3);
      run_instr(op, fw, mw, cpi(op, fw, mw), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
